// File: rtl/snake_engine.sv
// Snake Wars game-state core: per-player ring-buffer bodies, tick-driven stepping,
// food/collision detection, outcome reporting and a registered cell-occupancy query.
module snake_engine #(
  parameter int unsigned MAP_W     = 32,
  parameter int unsigned MAP_H     = 32,
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned START_LEN = 3,
  localparam int unsigned X_W = $clog2(MAP_W),
  localparam int unsigned Y_W = $clog2(MAP_H),
  localparam int unsigned L_W = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     tick,
  input  logic [2*N_PLAYERS-1:0]   dir,
  input  logic [X_W-1:0]           food_x,
  input  logic [Y_W-1:0]           food_y,
  input  logic                     food_valid,
  output logic                     eat,
  output logic [1:0]               eat_id,
  output logic [N_PLAYERS*L_W-1:0] len,
  output logic [N_PLAYERS-1:0]     alive,
  output logic                     busy,
  output logic                     step_done,
  output logic                     won,
  output logic                     lost,
  output logic                     draw,
  input  logic [X_W-1:0]           q_x,
  input  logic [Y_W-1:0]           q_y,
  output logic                     q_hit,
  output logic                     q_head,
  output logic [1:0]               q_id
);
  localparam int unsigned P_W = $clog2(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_LATCH, S_MOVE, S_CHECK, S_OVER} state_t;

  state_t               state, state_next;
  logic [X_W-1:0]       seg_x    [N_PLAYERS][MAX_LEN];
  logic [Y_W-1:0]       seg_y    [N_PLAYERS][MAX_LEN];
  logic [P_W-1:0]       head_ptr [N_PLAYERS];
  logic [L_W-1:0]       len_r    [N_PLAYERS];
  logic [1:0]           last_dir [N_PLAYERS];
  logic [X_W-1:0]       old_x    [N_PLAYERS];
  logic [Y_W-1:0]       old_y    [N_PLAYERS];
  logic [X_W-1:0]       head_x   [N_PLAYERS];
  logic [Y_W-1:0]       head_y   [N_PLAYERS];
  logic [X_W-1:0]       nxt_x    [N_PLAYERS];
  logic [Y_W-1:0]       nxt_y    [N_PLAYERS];
  logic [N_PLAYERS-1:0] alive_r, ate, grow, dies, alive_nx;
  logic                 do_init, do_latch, do_move, do_check;
  logic                 over_c, won_c, lost_c, draw_c;
  logic [1:0]           eat_id_c;
  logic                 busy_nx, eat_nx, step_done_nx, won_nx, lost_nx, draw_nx;
  logic [1:0]           eat_id_nx;
  logic                 q_hit_c, q_head_c;
  logic [1:0]           q_id_c;

  // Initial body x for slot s of player p; slot START_LEN-1 holds the head.
  function automatic logic [X_W-1:0] init_x(int p, int s);
    int mw, i, x;
    mw = int'(MAP_W);
    i  = int'(START_LEN) - 1 - s;
    x  = 2 + p * (mw / int'(N_PLAYERS));
    x  = (p % 2 == 0) ? x - i : x + i;
    x  = ((x % mw) + mw) % mw;
    return (i >= 0) ? X_W'(x) : '0;
  endfunction

  function automatic logic [X_W-1:0] step_x(logic [X_W-1:0] x, logic [1:0] d);
    logic [X_W-1:0] r;
    r = x;
    if (d == 2'd1)      r = (x == X_W'(MAP_W - 1)) ? '0 : x + X_W'(1);
    else if (d == 2'd3) r = (x == '0) ? X_W'(MAP_W - 1) : x - X_W'(1);
    return r;
  endfunction

  function automatic logic [Y_W-1:0] step_y(logic [Y_W-1:0] y, logic [1:0] d);
    logic [Y_W-1:0] r;
    r = y;
    if (d == 2'd2)      r = (y == Y_W'(MAP_H - 1)) ? '0 : y + Y_W'(1);
    else if (d == 2'd0) r = (y == '0) ? Y_W'(MAP_H - 1) : y - Y_W'(1);
    return r;
  endfunction

  function automatic logic [P_W-1:0] ptr_inc(logic [P_W-1:0] hp);
    return (hp == P_W'(MAX_LEN - 1)) ? '0 : hp + P_W'(1);
  endfunction

  // Segment index held by slot s: (head_ptr - s) mod MAX_LEN.
  function automatic int seg_idx(logic [P_W-1:0] hp, int s);
    int h;
    h = int'(hp);
    return (h >= s) ? h - s : h + int'(MAX_LEN) - s;
  endfunction

  // Current heads, candidate new heads and food pickup.
  always_comb begin
    for (int p = 0; p < int'(N_PLAYERS); p++) begin
      head_x[p] = seg_x[p][head_ptr[p]];
      head_y[p] = seg_y[p][head_ptr[p]];
      nxt_x[p]  = step_x(head_x[p], last_dir[p]);
      nxt_y[p]  = step_y(head_y[p], last_dir[p]);
      grow[p]   = alive_r[p] && food_valid && (nxt_x[p] == food_x) && (nxt_y[p] == food_y);
    end
  end

  // Collision detection on post-move buffers: body hits, head-to-head and head swaps.
  always_comb begin
    dies = '0;
    for (int p = 0; p < int'(N_PLAYERS); p++) begin
      if (alive_r[p]) begin
        for (int q = 0; q < int'(N_PLAYERS); q++) begin
          for (int s = 0; s < int'(MAX_LEN); s++) begin
            if ((seg_idx(head_ptr[q], s) < int'(len_r[q])) &&
                !(q == p && s == int'(head_ptr[q])) &&
                (seg_x[q][s] == head_x[p]) && (seg_y[q][s] == head_y[p]))
              dies[p] = 1'b1;
          end
          if ((q != p) && alive_r[q] &&
              (head_x[p] == old_x[q]) && (head_y[p] == old_y[q]) &&
              (head_x[q] == old_x[p]) && (head_y[q] == old_y[p]))
            dies[p] = 1'b1;
        end
      end
    end
    alive_nx = alive_r & ~dies;
  end

  // Game outcome from player 0's perspective, plus lowest-index eater.
  always_comb begin
    won_c  = 1'b0;
    lost_c = 1'b0;
    draw_c = 1'b0;
    if (N_PLAYERS == 1) begin
      lost_c = !alive_nx[0];
      won_c  = alive_nx[0] && (len_r[0] == L_W'(MAX_LEN));
    end else begin
      draw_c = (alive_nx == '0);
      lost_c = !draw_c && !alive_nx[0];
      won_c  = (alive_nx == N_PLAYERS'(1));
    end
    over_c   = won_c | lost_c | draw_c;
    eat_id_c = '0;
    for (int p = int'(N_PLAYERS) - 1; p >= 0; p--)
      if (ate[p]) eat_id_c = 2'(p);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // FSM next state, datapath strobes and next values of registered outputs.
  always_comb begin
    state_next   = state;
    do_init      = 1'b0;
    do_latch     = 1'b0;
    do_move      = 1'b0;
    do_check     = 1'b0;
    if (start) begin
      state_next = S_RUN;
      do_init    = 1'b1;
    end else begin
      case (state)
        S_IDLE:  state_next = S_IDLE;
        S_RUN:   if (tick) state_next = S_LATCH;
        S_LATCH: begin do_latch = 1'b1; state_next = S_MOVE; end
        S_MOVE:  begin do_move  = 1'b1; state_next = S_CHECK; end
        S_CHECK: begin do_check = 1'b1; state_next = over_c ? S_OVER : S_RUN; end
        S_OVER:  state_next = S_OVER;
        default: state_next = S_IDLE;
      endcase
    end
    busy_nx      = (state_next == S_LATCH) || (state_next == S_MOVE) || (state_next == S_CHECK);
    eat_nx       = do_check && (|ate);
    eat_id_nx    = do_check ? eat_id_c : eat_id;
    step_done_nx = do_check;
    won_nx       = won;
    lost_nx      = lost;
    draw_nx      = draw;
    if (do_init) begin
      won_nx  = 1'b0;
      lost_nx = 1'b0;
      draw_nx = 1'b0;
    end else if (do_check && over_c) begin
      won_nx  = won_c;
      lost_nx = lost_c;
      draw_nx = draw_c;
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0; eat <= 1'b0; eat_id <= '0; step_done <= 1'b0;
      won  <= 1'b0; lost <= 1'b0; draw <= 1'b0;
    end else begin
      busy <= busy_nx; eat <= eat_nx; eat_id <= eat_id_nx; step_done <= step_done_nx;
      won  <= won_nx;  lost <= lost_nx; draw <= draw_nx;
    end
  end

  // Snake bodies: init layout, direction latch, head advance and alive update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < int'(N_PLAYERS); p++) begin
        for (int s = 0; s < int'(MAX_LEN); s++) begin
          seg_x[p][s] <= init_x(p, s);
          seg_y[p][s] <= Y_W'(MAP_H / 2);
        end
        head_ptr[p] <= P_W'(START_LEN - 1);
        len_r[p]    <= L_W'(START_LEN);
        last_dir[p] <= (p % 2 == 0) ? 2'd1 : 2'd3;
        old_x[p]    <= '0;
        old_y[p]    <= '0;
      end
      alive_r <= '1;
      ate     <= '0;
    end else if (do_init) begin
      for (int p = 0; p < int'(N_PLAYERS); p++) begin
        for (int s = 0; s < int'(MAX_LEN); s++) begin
          seg_x[p][s] <= init_x(p, s);
          seg_y[p][s] <= Y_W'(MAP_H / 2);
        end
        head_ptr[p] <= P_W'(START_LEN - 1);
        len_r[p]    <= L_W'(START_LEN);
        last_dir[p] <= (p % 2 == 0) ? 2'd1 : 2'd3;
        old_x[p]    <= '0;
        old_y[p]    <= '0;
      end
      alive_r <= '1;
      ate     <= '0;
    end else if (do_latch) begin
      for (int p = 0; p < int'(N_PLAYERS); p++)
        if (alive_r[p] && (dir[2*p +: 2] != (last_dir[p] ^ 2'd2)))
          last_dir[p] <= dir[2*p +: 2];
    end else if (do_move) begin
      for (int p = 0; p < int'(N_PLAYERS); p++) begin
        ate[p] <= grow[p];
        if (alive_r[p]) begin
          head_ptr[p]                    <= ptr_inc(head_ptr[p]);
          seg_x[p][ptr_inc(head_ptr[p])] <= nxt_x[p];
          seg_y[p][ptr_inc(head_ptr[p])] <= nxt_y[p];
          old_x[p]                       <= head_x[p];
          old_y[p]                       <= head_y[p];
          if (grow[p] && (len_r[p] < L_W'(MAX_LEN)))
            len_r[p] <= len_r[p] + L_W'(1);
        end
      end
    end else if (do_check) begin
      alive_r <= alive_nx;
    end
  end

  // Occupancy query over live segments; lowest player index wins on overlap.
  always_comb begin
    logic hit_p, head_p;
    q_hit_c  = 1'b0;
    q_head_c = 1'b0;
    q_id_c   = '0;
    hit_p    = 1'b0;
    head_p   = 1'b0;
    for (int p = int'(N_PLAYERS) - 1; p >= 0; p--) begin
      hit_p  = 1'b0;
      head_p = 1'b0;
      for (int s = 0; s < int'(MAX_LEN); s++) begin
        if ((seg_idx(head_ptr[p], s) < int'(len_r[p])) &&
            (seg_x[p][s] == q_x) && (seg_y[p][s] == q_y)) begin
          hit_p = 1'b1;
          if (s == int'(head_ptr[p])) head_p = 1'b1;
        end
      end
      if (hit_p) begin
        q_hit_c  = 1'b1;
        q_head_c = head_p;
        q_id_c   = 2'(p);
      end
    end
  end

  // Registered query result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_hit <= 1'b0; q_head <= 1'b0; q_id <= '0;
    end else begin
      q_hit <= q_hit_c; q_head <= q_head_c; q_id <= q_id_c;
    end
  end

  // Pack per-player lengths and expose alive flags.
  always_comb begin
    for (int p = 0; p < int'(N_PLAYERS); p++)
      len[p*L_W +: L_W] = len_r[p];
  end
  assign alive = alive_r;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: 32x32 map, two players, MAX_LEN 16, START_LEN 3.
module tb_snake_engine;
  logic       clk = 1'b0;
  logic       rst, start, tick, food_valid, eat, busy, step_done, won, lost, draw;
  logic       q_hit, q_head;
  logic [3:0] dir;
  logic [4:0] food_x, food_y, q_x, q_y;
  logic [1:0] eat_id, alive, q_id;
  logic [9:0] len;
  int checks = 0;
  int errors = 0;

  snake_engine #(.MAP_W(32), .MAP_H(32), .N_PLAYERS(2), .MAX_LEN(16), .START_LEN(3)) dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .dir(dir),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .eat(eat), .eat_id(eat_id), .len(len), .alive(alive), .busy(busy),
    .step_done(step_done), .won(won), .lost(lost), .draw(draw),
    .q_x(q_x), .q_y(q_y), .q_hit(q_hit), .q_head(q_head), .q_id(q_id)
  );

  always #5 clk = ~clk;

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // One tick, then wait (bounded) for step_done; ok=0 if it never came.
  task automatic do_step(output bit ok);
    ok = 1'b0;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (step_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic set_query(input logic [4:0] x, input logic [4:0] y);
    q_x = x; q_y = y;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if ({eat, step_done, busy, won, lost, draw} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {eat, step_done, busy, won, lost, draw}); end
    checks++; if ({q_hit, q_head, q_id} !== 4'b0000) begin errors++; $display("FAIL reset_query got %b exp 0000", {q_hit, q_head, q_id}); end
    checks++; if (alive !== 2'b11) begin errors++; $display("FAIL reset_alive got %b exp 11", alive); end
    checks++; if (len !== {5'd3, 5'd3}) begin errors++; $display("FAIL reset_len got %h exp %h", len, {5'd3, 5'd3}); end
  endtask

  task automatic test_query();
    pulse_start();
    set_query(5'd2, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1100) begin errors++; $display("FAIL q_2_16 got %b exp 1100", {q_hit, q_head, q_id}); end
    set_query(5'd1, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1000) begin errors++; $display("FAIL q_1_16 got %b exp 1000", {q_hit, q_head, q_id}); end
    set_query(5'd18, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1101) begin errors++; $display("FAIL q_18_16 got %b exp 1101", {q_hit, q_head, q_id}); end
    set_query(5'd20, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1001) begin errors++; $display("FAIL q_20_16 got %b exp 1001", {q_hit, q_head, q_id}); end
    set_query(5'd5, 5'd5);
    checks++; if ({q_hit, q_head, q_id} !== 4'b0000) begin errors++; $display("FAIL q_5_5 got %b exp 0000", {q_hit, q_head, q_id}); end
  endtask

  task automatic test_move();
    pulse_start();
    dir = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL move_busy step %0d got %b exp 1", k, busy); end
      @(negedge clk);
      checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL move_early_done step %0d got %b exp 0", k, step_done); end
      @(negedge clk);
      checks++; if (step_done !== 1'b1) begin errors++; $display("FAIL move_done step %0d got %b exp 1", k, step_done); end
    end
    set_query(5'd7, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1100) begin errors++; $display("FAIL move_head got %b exp 1100", {q_hit, q_head, q_id}); end
    set_query(5'd5, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1000) begin errors++; $display("FAIL move_tail got %b exp 1000", {q_hit, q_head, q_id}); end
    set_query(5'd4, 5'd16);
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL move_vacated got %b exp 0", q_hit); end
    set_query(5'd13, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1101) begin errors++; $display("FAIL move_p1_head got %b exp 1101", {q_hit, q_head, q_id}); end
    checks++; if (len !== {5'd3, 5'd3}) begin errors++; $display("FAIL move_len got %h exp %h", len, {5'd3, 5'd3}); end
  endtask

  task automatic test_eat();
    pulse_start();
    dir = 4'b1101; food_x = 5'd3; food_y = 5'd16; food_valid = 1'b1;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (eat !== 1'b0) begin errors++; $display("FAIL eat_early got %b exp 0", eat); end
    @(negedge clk);
    food_valid = 1'b0;
    checks++; if ({eat, eat_id} !== 3'b100) begin errors++; $display("FAIL eat_pulse got %b exp 100", {eat, eat_id}); end
    checks++; if (len !== {5'd3, 5'd4}) begin errors++; $display("FAIL eat_len got %h exp %h", len, {5'd3, 5'd4}); end
    @(negedge clk);
    checks++; if (eat !== 1'b0) begin errors++; $display("FAIL eat_one_cycle got %b exp 0", eat); end
    set_query(5'd0, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1000) begin errors++; $display("FAIL eat_tail_kept got %b exp 1000", {q_hit, q_head, q_id}); end
    set_query(5'd3, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1100) begin errors++; $display("FAIL eat_head got %b exp 1100", {q_hit, q_head, q_id}); end
  endtask

  task automatic test_reverse();
    bit ok;
    pulse_start();
    dir = 4'b0011;
    do_step(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rev_step_timeout got %b exp 1", ok); end
    checks++; if (alive !== 2'b11) begin errors++; $display("FAIL rev_alive got %b exp 11", alive); end
    set_query(5'd3, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1100) begin errors++; $display("FAIL rev_head got %b exp 1100", {q_hit, q_head, q_id}); end
    set_query(5'd0, 5'd16);
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL rev_vacated got %b exp 0", q_hit); end
  endtask

  task automatic test_back_to_back();
    int dones;
    pulse_start();
    dir = 4'b1101;
    dones = 0;
    @(negedge clk) tick = 1'b1;
    @(negedge clk);
    @(negedge clk) tick = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (step_done) dones++;
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL b2b_steps got %0d exp 1", dones); end
    set_query(5'd3, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1100) begin errors++; $display("FAIL b2b_head got %b exp 1100", {q_hit, q_head, q_id}); end
    set_query(5'd4, 5'd16);
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL b2b_no_second got %b exp 0", q_hit); end
  endtask

  task automatic test_wrap();
    bit ok;
    int good;
    pulse_start();
    dir = 4'b0001;
    good = 0;
    for (int k = 0; k < 29; k++) begin
      do_step(ok);
      if (ok) good++;
    end
    checks++; if (good !== 29) begin errors++; $display("FAIL wrap_steps got %0d exp 29", good); end
    set_query(5'd31, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1100) begin errors++; $display("FAIL wrap_edge_head got %b exp 1100", {q_hit, q_head, q_id}); end
    do_step(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_last_step got %b exp 1", ok); end
    checks++; if (alive !== 2'b11) begin errors++; $display("FAIL wrap_alive got %b exp 11", alive); end
    set_query(5'd0, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1100) begin errors++; $display("FAIL wrap_head got %b exp 1100", {q_hit, q_head, q_id}); end
    set_query(5'd31, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1000) begin errors++; $display("FAIL wrap_body got %b exp 1000", {q_hit, q_head, q_id}); end
    set_query(5'd18, 5'd18);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1101) begin errors++; $display("FAIL wrap_p1_y got %b exp 1101", {q_hit, q_head, q_id}); end
  endtask

  task automatic test_collide();
    bit ok;
    int good;
    int dones;
    pulse_start();
    dir = 4'b1101;
    good = 0;
    for (int k = 0; k < 8; k++) begin
      do_step(ok);
      if (ok) good++;
    end
    checks++; if (good !== 8) begin errors++; $display("FAIL col_steps got %0d exp 8", good); end
    checks++; if (alive !== 2'b00) begin errors++; $display("FAIL col_alive got %b exp 00", alive); end
    checks++; if ({won, lost, draw} !== 3'b001) begin errors++; $display("FAIL col_outcome got %b exp 001", {won, lost, draw}); end
    dones = 0;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (step_done || busy) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL col_tick_ignored got %0d exp 0", dones); end
    checks++; if (draw !== 1'b1) begin errors++; $display("FAIL col_draw_sticky got %b exp 1", draw); end
    pulse_start();
    checks++; if ({alive, won, lost, draw} !== 5'b11000) begin errors++; $display("FAIL col_restart got %b exp 11000", {alive, won, lost, draw}); end
    checks++; if (len !== {5'd3, 5'd3}) begin errors++; $display("FAIL col_restart_len got %h exp %h", len, {5'd3, 5'd3}); end
    set_query(5'd2, 5'd16);
    checks++; if ({q_hit, q_head, q_id} !== 4'b1100) begin errors++; $display("FAIL col_restart_p0 got %b exp 1100", {q_hit, q_head, q_id}); end
    set_query(5'd10, 5'd16);
    checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL col_restart_clear got %b exp 0", q_hit); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; tick = 1'b0; dir = 4'b1101;
    food_x = 5'd0; food_y = 5'd0; food_valid = 1'b0; q_x = 5'd0; q_y = 5'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_query();
    test_move();
    test_eat();
    test_reverse();
    test_back_to_back();
    test_wrap();
    test_collide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
